// File: rtl/cheat_code_loader.sv
// cheat_code_loader: takes the cheat file as a byte stream from the downloader,
// builds 16-byte records and hands each one to the code engine over the
// 129-bit code word (data on [127:0], clock bit on [128]).
//
// Handshake: the downloader offers a byte with ioctl_wr and it is taken on any
// rising clk edge where ioctl_wr=1 and ioctl_wait=0. ioctl_wait is high while a
// finished record is waiting for the transmit FSM, so at most one record waits
// while another is being handed over.
module cheat_code_loader #(
    parameter logic [7:0] DL_INDEX      = 8'd4,
    parameter int         SETUP_CYCLES  = 2,
    parameter int         STROBE_CYCLES = 2,
    parameter int         GAP_CYCLES    = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ioctl_download,
    input  logic [7:0]   ioctl_index,
    input  logic         ioctl_wr,
    input  logic [7:0]   ioctl_dout,
    output logic         ioctl_wait,
    output logic         codes_clear,
    output logic [128:0] code,
    output logic         busy,
    output logic [7:0]   code_count,
    output logic         partial_err
);

    // The phase counter must hold the largest (cycles - 1) value of the three phases.
    localparam int MAX_AB = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_C  = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   tcnt_q;
    logic            act;
    logic            act_q;
    logic            start;
    logic            stop;
    logic            byte_ok;
    logic            rec_done;
    logic [3:0]      byte_cnt_q;
    // Only 15 bytes are ever held here: the 16th byte completes the record
    // and goes straight into the pending register together with them.
    logic [119:0]    shift_q;
    logic [127:0]    shift_d;
    logic [127:0]    pend_q;
    logic            pend_valid_q;
    logic [127:0]    code_q;
    logic            strobe_q;
    logic [7:0]      code_count_q;
    logic            partial_err_q;
    logic            codes_clear_q;

    assign act      = ioctl_download && (ioctl_index == DL_INDEX);
    assign start    = act && !act_q;
    assign stop     = !act && act_q;
    // A byte arriving on the start edge is dropped so every record begins at byte 0.
    assign byte_ok  = act && ioctl_wr && !pend_valid_q && !start;
    assign rec_done = byte_ok && (byte_cnt_q == 4'd15);
    assign shift_d  = {shift_q, ioctl_dout};

    assign ioctl_wait  = pend_valid_q;
    assign codes_clear = codes_clear_q;
    assign code        = {strobe_q, code_q};
    assign busy        = (state_q != S_IDLE) || pend_valid_q;
    assign code_count  = code_count_q;
    assign partial_err = partial_err_q;

    // Download edge detection, byte assembly and partial-record tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q         <= 1'b0;
            codes_clear_q <= 1'b0;
            byte_cnt_q    <= 4'd0;
            shift_q       <= '0;
            partial_err_q <= 1'b0;
        end else begin
            act_q         <= act;
            codes_clear_q <= start;
            if (start) begin
                byte_cnt_q    <= 4'd0;
                shift_q       <= '0;
                partial_err_q <= 1'b0;
            end else if (stop) begin
                if (byte_cnt_q != 4'd0) begin
                    partial_err_q <= 1'b1;
                    byte_cnt_q    <= 4'd0;
                end
            end else if (byte_ok) begin
                shift_q    <= shift_d[119:0];
                byte_cnt_q <= byte_cnt_q + 4'd1;
            end
        end
    end

    // Pending record slot and the transmit FSM that drives the code word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tcnt_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            code_q       <= '0;
            strobe_q     <= 1'b0;
            code_count_q <= 8'd0;
        end else if (start) begin
            // A new download aborts whatever is in flight.
            state_q      <= S_IDLE;
            tcnt_q       <= '0;
            pend_valid_q <= 1'b0;
            code_q       <= '0;
            strobe_q     <= 1'b0;
            code_count_q <= 8'd0;
        end else begin
            if (rec_done) begin
                pend_q       <= shift_d;
                pend_valid_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (pend_valid_q) begin
                        code_q       <= pend_q;
                        strobe_q     <= 1'b0;
                        pend_valid_q <= 1'b0;
                        tcnt_q       <= '0;
                        state_q      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tcnt_q == CW'(SETUP_CYCLES - 1)) begin
                        tcnt_q   <= '0;
                        strobe_q <= 1'b1;
                        state_q  <= S_STROBE;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                S_STROBE: begin
                    if (tcnt_q == CW'(STROBE_CYCLES - 1)) begin
                        tcnt_q   <= '0;
                        strobe_q <= 1'b0;
                        state_q  <= S_GAP;
                        if (code_count_q != 8'hFF) begin
                            code_count_q <= code_count_q + 8'd1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (tcnt_q == CW'(GAP_CYCLES - 1)) begin
                        tcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cheat_code_loader.md
Name: cheat_code_loader

Overview:
- Transmit side of the 129-bit cheat code word interface.
- Receives the cheat file as a byte stream from the download channel and assembles 16-byte records.
- Presents each record on code[127:0] and pulses code[128] (the clock bit) so the code engine latches it on the rising edge.
- Also issues the engine's clear at the start of each cheat download and stalls the downloader while a record is still being handed over.

Parameters:
- DL_INDEX, 8'd4: ioctl_index value identifying a cheat download.
- SETUP_CYCLES, 2: cycles code[127:0] is stable with code[128]=0 before the strobe (min 1).
- STROBE_CYCLES, 2: cycles code[128] is held high (min 1).
- GAP_CYCLES, 1: cycles code[128] is held low after the strobe before the next record (min 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  byte strobe; a byte is accepted when ioctl_wr=1 and ioctl_wait=0.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  stall request to the downloader.
- codes_clear  out  1  one-cycle clear pulse to the code engine (its reset input).
- code  out  129  {clock bit, flags[31:0], addr[31:0], compare[31:0], replace[31:0]}.
- busy  out  1  transmit FSM not in IDLE, or a record is pending.
- code_count  out  8  records transmitted since download start; saturates at 255.
- partial_err  out  1  sticky: the last download ended with a partial record.

Behaviour:
- Reset: async on reset_n=0. All outputs 0; FSM in IDLE; byte counter 0; pending_valid 0.
- Active download (act):
  - act = ioctl_download && ioctl_index==DL_INDEX.
  - Rising edge of act (registered compare):
    - codes_clear=1 for exactly one cycle.
    - Byte counter, code_count and partial_err cleared.
    - code[128:0] driven to 0.
    - pending_valid cleared; FSM forced to IDLE.
  - Bytes are ignored when act=0.
- Assembly:
  - 128-bit shift register; each accepted byte shifts in at the LSB end.
  - Byte 0 of a record ends in bits [127:120]; byte 15 ends in [7:0]. The file's big-endian order is preserved; no swapping.
  - 4-bit byte counter wraps 15->0.
  - When byte 15 is accepted, the shift value including that byte is copied to the pending register; pending_valid=1 the next cycle.
- Stall: ioctl_wait = pending_valid. At most one pending record plus one in transmission.
- Transmit FSM:
  - IDLE, pending_valid=1:
    - Load code[127:0] from pending; code[128]=0.
    - Clear pending_valid; go SETUP.
  - SETUP: count SETUP_CYCLES, then go STROBE.
  - STROBE: code[128]=1 for STROBE_CYCLES; on exit, code_count+1 (saturating at 255); go GAP.
  - GAP: code[128]=0 for GAP_CYCLES, then go IDLE.
  - code[127:0] holds its value until the next load, including after the download ends.
  - Back-to-back records: the rising edges of code[128] are separated by at least SETUP+STROBE+GAP cycles.
- Download end (falling edge of act):
  - Byte counter != 0: set partial_err, discard the partial bytes, reset the counter.
  - A pending or in-flight record still completes.
- Simultaneous events:
  - Start edge while the FSM is mid-record: the start edge wins (abort, clear).
  - A byte accepted in the same cycle as the start edge is dropped.
- Mid-operation reset: asynchronous; all state returns to reset values immediately.
- Counter widths: SETUP/STROBE/GAP counters are wide enough for the maximum parameter value; a parameter of 1 gives exactly one cycle.

Test Plan:
- Reset and start:
  - Stimulus: assert reset_n=0, release, raise ioctl_download with index 4.
  - Required: all outputs 0; codes_clear high for exactly one cycle; no pulse for index 3.
- Single record:
  - Stimulus: bytes 00 00 00 01, 00 00 C1 23, 00 00 00 3E, 00 00 00 99.
  - Required: code[127:0]=0x00000001_0000C123_0000003E_00000099; code[128] low 2 cycles, then high 2 cycles; code_count=1.
- Back-to-back records with ioctl_wr every cycle:
  - Stimulus: 32 bytes on consecutive cycles.
  - Required: ioctl_wait asserts while the second record is pending; no byte lost; two code[128] rising edges at least 5 cycles apart; code_count=2; second record value correct.
- Partial record:
  - Stimulus: 20 bytes, then drop ioctl_download.
  - Required: one record transmitted; partial_err=1; the next download start clears partial_err.
- Abort:
  - Stimulus: start a new download while in STROBE.
  - Required: code[128] drops the next cycle; codes_clear pulses; code_count=0; the first new record is assembled from byte 0.
- Async reset mid-SETUP:
  - Stimulus: reset_n=0 during SETUP.
  - Required: code=0, busy=0 immediately, without waiting for a clock edge.
